// File: rtl/clause_variable_picker.sv
// Reads one clause's coefficient words, derives per-variable presence masks and
// picks one present variable by scanning the combined position space from a random offset.
module clause_variable_picker #(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2,
    parameter int CLAUSE_INDEX_WIDTH                          = 4,
    localparam int NI  = 1 << MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
    localparam int NB  = 1 << MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
    localparam int M   = (MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX > MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)
                         ? MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX
                         : MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
    localparam int ICW = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
    localparam int BCW = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_start,
    input  logic [CLAUSE_INDEX_WIDTH-1:0] in_clause_index,
    input  logic [M:0]                    in_random,
    output logic                          out_mem_rd_en,
    output logic [CLAUSE_INDEX_WIDTH-1:0] out_mem_addr,
    input  logic [NI*ICW-1:0]             in_mem_integer_coefficients,
    input  logic [NB*BCW-1:0]             in_mem_boolean_coefficients,
    output logic                          out_busy,
    output logic                          out_done,
    output logic                          out_empty,
    output logic                          out_var_is_boolean,
    output logic [M-1:0]                  out_var_index,
    output logic [NI-1:0]                 out_integer_variables,
    output logic [NB-1:0]                 out_boolean_variables
);

    localparam int TOTAL = NI + NB;
    localparam int PW    = M + 1;
    localparam int SW    = M + 2;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SCAN, S_DONE} state_t;

    state_t                        state, state_d;
    logic [CLAUSE_INDEX_WIDTH-1:0] clause_q;
    logic [PW-1:0]                 start_q, pos_q, start_off, pos_next;
    logic [SW-1:0]                 steps_q;
    logic [NI-1:0]                 int_present;
    logic [NB-1:0]                 bool_present;
    logic [TOTAL-1:0]              presence;
    logic                          hit, last_probe, pos_is_int;
    logic [M-1:0]                  bool_idx;

    always_comb begin
        int_present  = '0;
        bool_present = '0;
        hit          = 1'b0;
        for (int i = 0; i < NI; i++) int_present[i] = |in_mem_integer_coefficients[i*ICW +: ICW];
        for (int i = 0; i < NB; i++) bool_present[i] = |in_mem_boolean_coefficients[i*BCW +: BCW];
        presence = {out_boolean_variables, out_integer_variables};
        for (int i = 0; i < TOTAL; i++) begin
            if (pos_q == PW'(i)) hit = presence[i];
        end
        // in_random < 2*TOTAL always, so a single conditional subtraction reduces it.
        start_off  = ({1'b0, in_random} < SW'(TOTAL)) ? in_random : in_random - PW'(TOTAL);
        pos_next   = (pos_q == PW'(TOTAL - 1)) ? '0 : pos_q + 1'b1;
        last_probe = (steps_q == SW'(TOTAL - 1));
        pos_is_int = (pos_q < PW'(NI));
        bool_idx   = pos_q[M-1:0] - M'(NI);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d       = state;
        out_busy      = (state != S_IDLE);
        out_done      = 1'b0;
        out_mem_rd_en = 1'b0;
        out_mem_addr  = '0;
        case (state)
            S_IDLE: if (in_start) state_d = S_READ;
            S_READ: begin
                out_mem_rd_en = 1'b1;
                out_mem_addr  = clause_q;
                state_d       = S_WAIT;
            end
            S_WAIT: state_d = S_SCAN;
            S_SCAN: if (hit || last_probe) state_d = S_DONE;
            S_DONE: begin
                out_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clause_q              <= '0;
            start_q               <= '0;
            pos_q                 <= '0;
            steps_q               <= '0;
            out_integer_variables <= '0;
            out_boolean_variables <= '0;
            out_empty             <= 1'b0;
            out_var_is_boolean    <= 1'b0;
            out_var_index         <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_start) begin
                    clause_q <= in_clause_index;
                    start_q  <= start_off;
                    steps_q  <= '0;
                end
                S_WAIT: begin
                    out_integer_variables <= int_present;
                    out_boolean_variables <= bool_present;
                    pos_q                 <= start_q;
                    out_empty             <= 1'b0;
                    out_var_is_boolean    <= 1'b0;
                    out_var_index         <= '0;
                end
                S_SCAN: begin
                    if (hit) begin
                        out_var_is_boolean <= !pos_is_int;
                        out_var_index      <= pos_is_int ? pos_q[M-1:0] : bool_idx;
                    end else begin
                        pos_q   <= pos_next;
                        steps_q <= steps_q + 1'b1;
                        // Result fields were cleared in WAIT, so empty needs only the flag.
                        if (last_probe) out_empty <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clause_variable_picker.sv
// Directed bench for clause_variable_picker: a list-based picking model drives a
// per-cycle compare process; literal expectations pin both the model and the DUT.
module tb_clause_variable_picker;

    logic clk = 0;
    logic reset = 0;
    always #5 clk = ~clk;

    logic       in_start = 0;
    logic [3:0] in_clause_index = 0;
    logic [1:0] in_random = 0;
    logic       out_mem_rd_en;
    logic [3:0] out_mem_addr;
    logic [7:0] rd_int = 0;
    logic [3:0] rd_bool = 0;
    logic       out_busy, out_done, out_empty, out_var_is_boolean;
    logic [0:0] out_var_index;
    logic [1:0] out_integer_variables, out_boolean_variables;

    logic       s3_start = 0;
    logic [1:0] s3_random = 0;
    logic       s3_rd, s3_busy, s3_done, s3_empty, s3_isb;
    logic [3:0] s3_addr;
    logic [0:0] s3_idx, s3_bmask;
    logic [1:0] s3_imask;

    clause_variable_picker dut (
        .clk(clk), .reset(reset), .in_start(in_start), .in_clause_index(in_clause_index),
        .in_random(in_random), .out_mem_rd_en(out_mem_rd_en), .out_mem_addr(out_mem_addr),
        .in_mem_integer_coefficients(rd_int), .in_mem_boolean_coefficients(rd_bool),
        .out_busy(out_busy), .out_done(out_done), .out_empty(out_empty),
        .out_var_is_boolean(out_var_is_boolean), .out_var_index(out_var_index),
        .out_integer_variables(out_integer_variables), .out_boolean_variables(out_boolean_variables)
    );

    // One boolean variable: TOTAL = 3, so the random offset may need reducing.
    clause_variable_picker #(.MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX(0)) dut3 (
        .clk(clk), .reset(reset), .in_start(s3_start), .in_clause_index(4'd0),
        .in_random(s3_random), .out_mem_rd_en(s3_rd), .out_mem_addr(s3_addr),
        .in_mem_integer_coefficients(8'h30), .in_mem_boolean_coefficients(2'b01),
        .out_busy(s3_busy), .out_done(s3_done), .out_empty(s3_empty),
        .out_var_is_boolean(s3_isb), .out_var_index(s3_idx),
        .out_integer_variables(s3_imask), .out_boolean_variables(s3_bmask)
    );

    logic [7:0] mem_int[16];
    logic [3:0] mem_bool[16];
    always @(posedge clk) begin
        if (out_mem_rd_en) begin
            rd_int  <= mem_int[out_mem_addr];
            rd_bool <= mem_bool[out_mem_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    bit m_active = 0;
    int m_t = 0, m_done = 0;
    logic [3:0] m_addr = 0;
    int m_lat = 0, m_empty = 0, m_isb = 0, m_idx = 0, m_im = 0, m_bm = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Lists the present variables in position order, then takes the first one at or after
    // the start offset going round the circle.
    function automatic void model_pick(input int rnd, input logic [7:0] ci, input logic [3:0] cb,
                                       output int lat, output int empty, output int isb,
                                       output int idx, output int im, output int bm);
        int pres[4];
        int s;
        int p;
        im = 0;
        bm = 0;
        for (int i = 0; i < 2; i++) begin
            pres[i] = (ci[i*4 +: 4] != 4'd0) ? 1 : 0;
            im += pres[i] << i;
            pres[2+i] = (cb[i*2 +: 2] != 2'd0) ? 1 : 0;
            bm += pres[2+i] << i;
        end
        s = rnd % 4;
        lat = 3 + 4;
        empty = 1;
        isb = 0;
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            p = (s + k) % 4;
            if (pres[p] != 0) begin
                lat = 4 + k;
                empty = 0;
                isb = (p >= 2) ? 1 : 0;
                idx = (p >= 2) ? p - 2 : p;
                break;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (reset) m_active = 0;
        else if (in_start && (!m_active || cyc > m_done)) begin
            m_active = 1;
            m_t = cyc;
            m_addr = in_clause_index;
            model_pick(int'(in_random), mem_int[in_clause_index], mem_bool[in_clause_index],
                       m_lat, m_empty, m_isb, m_idx, m_im, m_bm);
            m_done = cyc + m_lat;
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        int live, e_busy, e_rd, e_done, e_addr;
        live   = (m_active && !reset) ? 1 : 0;
        e_busy = (live != 0 && cyc >= m_t + 1 && cyc <= m_done) ? 1 : 0;
        e_rd   = (live != 0 && cyc == m_t + 1) ? 1 : 0;
        e_done = (live != 0 && cyc == m_done) ? 1 : 0;
        e_addr = (e_rd != 0) ? int'(m_addr) : 0;
        chk("busy", int'(out_busy), e_busy);
        chk("mem_rd_en", int'(out_mem_rd_en), e_rd);
        chk("mem_addr", int'(out_mem_addr), e_addr);
        chk("done", int'(out_done), e_done);
        if (e_done != 0) begin
            chk("empty", int'(out_empty), m_empty);
            chk("is_boolean", int'(out_var_is_boolean), m_isb);
            chk("var_index", int'(out_var_index), m_idx);
            chk("int_mask", int'(out_integer_variables), m_im);
            chk("bool_mask", int'(out_boolean_variables), m_bm);
        end
        if (out_mem_rd_en) rd_cnt++;
        if (out_done) done_cnt++;
    end

    task automatic launch(input logic [3:0] idx, input logic [1:0] rnd, output int t0);
        @(negedge clk); #1;
        in_start = 1;
        in_clause_index = idx;
        in_random = rnd;
        t0 = cyc;
        @(negedge clk); #1;
        in_start = 0;
    endtask

    task automatic wait_done(input int t0, output int lat);
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            if (out_done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    initial begin
        int t0, lat, d, rd0, dn0;
        int p_lat, p_empty, p_isb, p_idx, p_im, p_bm;
        for (int i = 0; i < 16; i++) begin
            mem_int[i] = 8'h00;
            mem_bool[i] = 4'h0;
        end
        mem_int[3] = 8'h05; mem_bool[3] = 4'hF;
        mem_int[4] = 8'h05; mem_bool[4] = 4'h0;
        mem_int[9] = 8'hF0; mem_bool[9] = 4'h4;

        #1 reset = 1;
        repeat (2) @(negedge clk);
        #1 reset = 0;
        chk("reset_busy", int'(out_busy), 0);
        chk("reset_rd_en", int'(out_mem_rd_en), 0);
        chk("reset_int_mask", int'(out_integer_variables), 0);
        chk("reset_bool_mask", int'(out_boolean_variables), 0);
        chk("reset_index", int'(out_var_index), 0);

        model_pick(1, 8'h05, 4'hF, p_lat, p_empty, p_isb, p_idx, p_im, p_bm);
        chk("pin_hit_lat", p_lat, 5);
        chk("pin_hit_isb", p_isb, 1);
        chk("pin_hit_masks", p_im * 4 + p_bm, 1 * 4 + 3);
        model_pick(2, 8'h00, 4'h0, p_lat, p_empty, p_isb, p_idx, p_im, p_bm);
        chk("pin_empty_lat", p_lat, 7);
        chk("pin_empty_flag", p_empty, 1);
        model_pick(3, 8'h05, 4'h0, p_lat, p_empty, p_isb, p_idx, p_im, p_bm);
        chk("pin_wrap_lat", p_lat, 5);
        chk("pin_wrap_isb", p_isb, 0);

        launch(4'd3, 2'd1, t0);
        wait_done(t0, lat);
        chk("hit_latency", lat, 5);
        chk("hit_is_boolean", int'(out_var_is_boolean), 1);
        chk("hit_index", int'(out_var_index), 0);
        chk("hit_masks", int'({out_integer_variables, out_boolean_variables}), 4'b0111);

        launch(4'd7, 2'd2, t0);
        wait_done(t0, lat);
        chk("empty_latency", lat, 7);
        chk("empty_flag", int'(out_empty), 1);

        launch(4'd4, 2'd3, t0);
        wait_done(t0, lat);
        chk("wrap_latency", lat, 5);
        chk("wrap_is_boolean", int'(out_var_is_boolean), 0);
        // Start held across the done cycle (ignored) and the first idle cycle (accepted).
        d = cyc;
        in_start = 1; in_clause_index = 4'd3; in_random = 2'd1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        in_start = 0;
        wait_done(d, lat);
        chk("restart_after_done_latency", lat, 6);

        rd0 = rd_cnt;
        dn0 = done_cnt;
        launch(4'd3, 2'd1, t0);
        @(negedge clk); #1;
        in_start = 1; in_clause_index = 4'd9; in_random = 2'd0;
        @(negedge clk); #1;
        in_start = 0;
        wait_done(t0, lat);
        chk("busy_ignore_latency", lat, 5);
        chk("busy_ignore_is_boolean", int'(out_var_is_boolean), 1);
        repeat (3) @(negedge clk);
        #1;
        chk("busy_ignore_rd_count", rd_cnt - rd0, 1);
        chk("busy_ignore_done_count", done_cnt - dn0, 1);

        launch(4'd4, 2'd1, t0);
        repeat (3) @(negedge clk);
        #1 reset = 1;
        #1;
        chk("abort_busy", int'(out_busy), 0);
        chk("abort_done", int'(out_done), 0);
        chk("abort_int_mask", int'(out_integer_variables), 0);
        chk("abort_empty", int'(out_empty), 0);
        dn0 = done_cnt;
        repeat (2) @(negedge clk);
        #1 reset = 0;
        repeat (8) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt - dn0, 0);
        launch(4'd3, 2'd1, t0);
        wait_done(t0, lat);
        chk("after_abort_latency", lat, 5);
        chk("after_abort_is_boolean", int'(out_var_is_boolean), 1);

        @(negedge clk); #1;
        s3_start = 1;
        s3_random = 2'd3;
        t0 = cyc;
        @(negedge clk); #1;
        s3_start = 0;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            if (s3_done) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk); #1;
        end
        chk("reduce_latency", lat, 5);
        chk("reduce_index", int'(s3_idx), 1);
        chk("reduce_is_boolean", int'(s3_isb), 0);
        chk("reduce_empty", int'(s3_empty), 0);
        chk("reduce_int_mask", int'(s3_imask), 2);
        chk("reduce_bool_mask", int'(s3_bmask), 1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clause_variable_picker.md
Name: clause_variable_picker

Overview:
- Sequencer for the variable-detection datapath of the MCMC solver.
- Given a clause index (normally the unsatisfied clause chosen at random), it reads that clause's coefficient words from the clause memory and derives per-variable presence masks: a variable is present when its coefficient is nonzero.
- It then picks one present variable, starting the scan from a random offset, and hands the choice to the proposal logic through a start/done handshake.

Parameters:
- MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX, 1, integer variables per clause NI = 2**value.
- MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX, 1, boolean variables per clause NB = 2**value (0 legal, gives NB=1).
- MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT, 4, bits per integer coefficient.
- MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT, 2, bits per boolean coefficient; 2'b00 means absent.
- CLAUSE_INDEX_WIDTH, 4, clause memory address width.
- Derived: M = max of the two index widths; TOTAL = NI+NB.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_start  in  1  request pulse; sampled only in IDLE.
- in_clause_index  in  CLAUSE_INDEX_WIDTH  clause to examine; latched with in_start.
- in_random  in  M+1  random offset; latched with in_start.
- out_mem_rd_en  out  1  clause memory read strobe.
- out_mem_addr  out  CLAUSE_INDEX_WIDTH  clause memory address.
- in_mem_integer_coefficients  in  NI*int-coef-width  memory read data, valid the cycle after out_mem_rd_en. Variable i occupies bits [i*W +: W].
- in_mem_boolean_coefficients  in  NB*bool-coef-width  memory read data, same timing and packing as the integer word.
- out_busy  out  1  high in every state except IDLE.
- out_done  out  1  one-cycle pulse; result outputs valid in that cycle.
- out_empty  out  1  with done: clause has no present variable.
- out_var_is_boolean  out  1  with done: chosen variable is boolean.
- out_var_index  out  M  with done: index within its class, zero-extended.
- out_integer_variables  out  NI  latched integer presence mask.
- out_boolean_variables  out  NB  latched boolean presence mask.

Behaviour:
- Reset (async, any state): state goes to IDLE. All outputs, latched registers and masks go to 0. out_mem_rd_en drops immediately; no done pulse is issued for the aborted request.
- Combined position space p in 0..TOTAL-1:
  - p < NI is integer variable p.
  - p >= NI is boolean variable p-NI.
- Start offset: start = in_random if in_random < TOTAL, else in_random - TOTAL. One subtraction always suffices.
- FSM states: IDLE, READ, WAIT, SCAN, DONE.
  - IDLE: on in_start=1 at cycle T, latch clause index, start offset and step counter=0; go to READ.
  - READ (T+1): out_mem_rd_en=1, out_mem_addr=latched index; go to WAIT.
  - WAIT (T+2): memory data valid. Latch both presence masks (reduction-OR per coefficient field); set p=start; go to SCAN.
  - SCAN (one position per cycle, from T+3):
    - If the mask bit at p is set, register the result and go to DONE.
    - Else p = (p==TOTAL-1) ? 0 : p+1 and steps++.
    - If steps reaches TOTAL with no hit, set out_empty=1, var outputs=0, go to DONE.
  - DONE: out_done=1 for exactly one cycle, then IDLE.
- Latency:
  - Hit on the k-th probe (k=0 first) gives done at T+4+k.
  - Empty clause gives done at T+3+TOTAL.
- Result outputs and masks hold their values after done until the next WAIT overwrites them.
- in_start is ignored while out_busy=1. Neither queueing nor abort is performed.
- in_start in the done cycle is ignored. in_start on the first IDLE cycle after done is accepted.
- out_mem_rd_en is high only in READ; address is 0 outside READ.

Test Plan (defaults NI=NB=2, TOTAL=4, M=1, start at cycle T):
- Clause 3: int 8'h05, bool 4'b1111, random=1 -> rd_en at T+1, addr 3. Masks 2'b01 and 2'b11. Position 1 absent, position 2 hit. Done at T+5 with is_boolean=1, index 0, empty=0.
- int 8'h00, bool 4'b0000, random=2 -> masks 0, done at T+7, empty=1, index 0, is_boolean 0.
- Wrap: int 8'h05, bool 4'b0000, random=3 -> position 3 absent, wraps to position 0. Done at T+5, integer index 0.
- Offset reduction: NB parameter width=0 (TOTAL=3), int 8'h30, bool 2'b01, random=3 -> start 0. Position 0 absent, position 1 hit. Done at T+5, integer index 1.
- Busy/start: second in_start with a different index at T+2 -> ignored. Only one rd_en, one done, and the first clause's result.
- Reset asserted mid-SCAN -> outputs 0 immediately. No done pulse follows. A new start after reset release completes normally.
